// File: rtl/allegro_codec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : allegro_codec_pkg
// Description : Shared types and constants for the codec configuration APB
//               path: bus field types, request bundle, arbiter state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package allegro_codec_pkg;

    localparam int DCD_TARG_CFG_APB_ADDR_W = 20;
    localparam int DCD_TARG_CFG_APB_DATA_W = 32;
    localparam int DCD_TARG_CFG_APB_STRB_W = DCD_TARG_CFG_APB_DATA_W / 8;
    localparam int DCD_CFG_APB_NUM_REQ     = 2;

    typedef logic [DCD_TARG_CFG_APB_ADDR_W-1:0] dcd_targ_cfg_apb_addr_t;
    typedef logic [DCD_TARG_CFG_APB_DATA_W-1:0] dcd_targ_cfg_apb_data_t;
    typedef logic [DCD_TARG_CFG_APB_STRB_W-1:0] dcd_targ_cfg_apb_strb_t;
    typedef logic [2:0]                         dcd_targ_cfg_apb_prot_t;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_SETUP  = 2'd1,
        ARB_ACCESS = 2'd2,
        ARB_RESP   = 2'd3
    } allegro_codec_apb_arb_state_e;

    typedef struct packed {
        dcd_targ_cfg_apb_addr_t addr;
        logic                   write;
        dcd_targ_cfg_apb_data_t wdata;
        dcd_targ_cfg_apb_strb_t strb;
        dcd_targ_cfg_apb_prot_t prot;
    } dcd_targ_cfg_apb_req_t;

endpackage : allegro_codec_pkg
`default_nettype wire

// File: rtl/allegro_codec_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : allegro_codec_rr_arb
// Description : Combinational round-robin picker; grants the first request
//               found after the pointer position, wrapping around.
// Revision    : 1.0  initial release
// ============================================================================
module allegro_codec_rr_arb #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_grant_vld
);

    logic [IDX_W-1:0] w_cand [NUM_REQ];

    // w_cand[k] is the index k+1 positions after the pointer, modulo NUM_REQ
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
        localparam logic [IDX_W:0] c_off = (IDX_W+1)'(k + 1);
        localparam logic [IDX_W:0] c_num = (IDX_W+1)'(NUM_REQ);
        logic [IDX_W:0] w_sum;
        logic [IDX_W:0] w_wrap;
        assign w_sum     = {1'b0, i_ptr} + c_off;
        assign w_wrap    = w_sum - c_num;
        assign w_cand[k] = (w_sum >= c_num) ? w_wrap[IDX_W-1:0] : w_sum[IDX_W-1:0];
    end

    always_comb begin
        o_grant_vld = 1'b0;
        o_grant_idx = '0;
        // Walk from farthest to nearest so the nearest requester wins
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req[w_cand[k]]) begin
                o_grant_vld = 1'b1;
                o_grant_idx = w_cand[k];
            end
        end
        o_grant = o_grant_vld ? (NUM_REQ'(1) << o_grant_idx) : '0;
    end

endmodule : allegro_codec_rr_arb
`default_nettype wire

// File: rtl/allegro_codec_apb_cfg_arb.sv
`default_nettype none
// ============================================================================
// Module      : allegro_codec_apb_cfg_arb
// Description : Round-robin arbiter sharing the codec configuration APB
//               target between NUM_REQ APB requesters; fully registered.
//               Optional macro ALLEGRO_CODEC_APB_CFG_ARB_PROT_EN rejects
//               unprivileged accesses to the protected window.
// Revision    : 1.0  initial release
// ============================================================================
module allegro_codec_apb_cfg_arb
    import allegro_codec_pkg::*;
#(
    parameter int                NUM_REQ   = DCD_CFG_APB_NUM_REQ,
    parameter int                ADDR_W    = DCD_TARG_CFG_APB_ADDR_W,
    parameter int                DATA_W    = DCD_TARG_CFG_APB_DATA_W,
    parameter logic [ADDR_W-1:0] PROT_BASE = ADDR_W'(20'hF_0000),
    parameter logic [ADDR_W-1:0] PROT_SIZE = ADDR_W'(20'h1_0000)
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic [NUM_REQ-1:0]                  i_s_psel,
    input  logic [NUM_REQ-1:0]                  i_s_penable,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]      i_s_paddr,
    input  logic [NUM_REQ-1:0]                  i_s_pwrite,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]      i_s_pwdata,
    input  logic [NUM_REQ-1:0][DATA_W/8-1:0]    i_s_pstrb,
    input  logic [NUM_REQ-1:0][2:0]             i_s_pprot,
    output logic [NUM_REQ-1:0][DATA_W-1:0]      o_s_prdata,
    output logic [NUM_REQ-1:0]                  o_s_pready,
    output logic [NUM_REQ-1:0]                  o_s_pslverr,
    output logic                                o_m_psel,
    output logic                                o_m_penable,
    output logic                                o_m_pwrite,
    output logic [ADDR_W-1:0]                   o_m_paddr,
    output logic [DATA_W-1:0]                   o_m_pwdata,
    output logic [DATA_W/8-1:0]                 o_m_pstrb,
    output logic [2:0]                          o_m_pprot,
    input  logic [DATA_W-1:0]                   i_m_prdata,
    input  logic                                i_m_pready,
    input  logic                                i_m_pslverr
);

    localparam int c_idx_w = $clog2(NUM_REQ);

    localparam logic [1:0] c_st_idle   = ARB_IDLE;
    localparam logic [1:0] c_st_setup  = ARB_SETUP;
    localparam logic [1:0] c_st_access = ARB_ACCESS;
    localparam logic [1:0] c_st_resp   = ARB_RESP;

    logic [1:0]         r_state;
    logic [c_idx_w-1:0] r_ptr;
    logic [c_idx_w-1:0] r_grant;

    logic [NUM_REQ-1:0] w_gnt_oh;
    logic [c_idx_w-1:0] w_gnt_idx;
    logic               w_gnt_vld;
    logic               w_prot_hit;

    allegro_codec_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_rr_arb (
        .i_req       (i_s_psel),
        .i_ptr       (r_ptr),
        .o_grant     (w_gnt_oh),
        .o_grant_idx (w_gnt_idx),
        .o_grant_vld (w_gnt_vld)
    );

`ifdef ALLEGRO_CODEC_APB_CFG_ARB_PROT_EN
    // Window end is computed one bit wider so a window ending at the top of
    // the address space does not wrap to zero
    localparam logic [ADDR_W:0] c_prot_lo = {1'b0, PROT_BASE};
    localparam logic [ADDR_W:0] c_prot_hi = {1'b0, PROT_BASE} + {1'b0, PROT_SIZE};
    logic [ADDR_W:0] w_sel_addr;
    assign w_sel_addr = {1'b0, i_s_paddr[w_gnt_idx]};
    assign w_prot_hit = !i_s_pprot[w_gnt_idx][0]
                        && (w_sel_addr >= c_prot_lo)
                        && (w_sel_addr <  c_prot_hi);
`else
    logic w_unused_prot;
    assign w_unused_prot = ^{PROT_BASE, PROT_SIZE};
    assign w_prot_hit    = 1'b0;
`endif

    logic w_unused;
    assign w_unused = ^{i_s_penable, w_gnt_oh};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= c_st_idle;
            r_ptr       <= c_idx_w'(NUM_REQ - 1);
            r_grant     <= '0;
            o_m_psel    <= 1'b0;
            o_m_penable <= 1'b0;
            o_m_pwrite  <= 1'b0;
            o_m_paddr   <= '0;
            o_m_pwdata  <= '0;
            o_m_pstrb   <= '0;
            o_m_pprot   <= '0;
            o_s_prdata  <= '0;
            o_s_pready  <= '0;
            o_s_pslverr <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_gnt_vld) begin
                        r_grant    <= w_gnt_idx;
                        r_ptr      <= w_gnt_idx;
                        o_m_paddr  <= i_s_paddr[w_gnt_idx];
                        o_m_pwrite <= i_s_pwrite[w_gnt_idx];
                        o_m_pwdata <= i_s_pwdata[w_gnt_idx];
                        o_m_pstrb  <= i_s_pstrb[w_gnt_idx];
                        o_m_pprot  <= i_s_pprot[w_gnt_idx];
                        if (w_prot_hit) begin
                            // Rejected locally: error response, codec untouched
                            o_s_pready[w_gnt_idx]  <= 1'b1;
                            o_s_pslverr[w_gnt_idx] <= 1'b1;
                            r_state                <= c_st_resp;
                        end else begin
                            o_m_psel <= 1'b1;
                            r_state  <= c_st_setup;
                        end
                    end
                end
                c_st_setup: begin
                    o_m_penable <= 1'b1;
                    r_state     <= c_st_access;
                end
                c_st_access: begin
                    if (i_m_pready) begin
                        o_m_psel             <= 1'b0;
                        o_m_penable          <= 1'b0;
                        o_s_prdata[r_grant]  <= o_m_pwrite ? '0 : i_m_prdata;
                        o_s_pslverr[r_grant] <= i_m_pslverr;
                        o_s_pready[r_grant]  <= 1'b1;
                        r_state              <= c_st_resp;
                    end
                end
                c_st_resp: begin
                    o_s_pready  <= '0;
                    o_s_pslverr <= '0;
                    o_s_prdata  <= '0;
                    r_state     <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule : allegro_codec_apb_cfg_arb
`default_nettype wire

// File: tb/tb_allegro_codec_apb_cfg_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_allegro_codec_apb_cfg_arb
// Description : Scoreboard bench for the codec configuration APB arbiter.
// Revision    : 1.0  initial release
// ============================================================================
module tb_allegro_codec_apb_cfg_arb;
    import allegro_codec_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       s_psel, s_penable, s_pwrite;
    logic [1:0][19:0] s_paddr;
    logic [1:0][31:0] s_pwdata;
    logic [1:0][3:0]  s_pstrb;
    logic [1:0][2:0]  s_pprot;
    logic [1:0][31:0] s_prdata;
    logic [1:0]       s_pready, s_pslverr;
    logic             m_psel, m_penable, m_pwrite;
    logic [19:0]      m_paddr;
    logic [31:0]      m_pwdata;
    logic [3:0]       m_pstrb;
    logic [2:0]       m_pprot;
    logic [31:0]      m_prdata;
    logic             m_pready, m_pslverr;

    always #5 clk = ~clk;

    allegro_codec_apb_cfg_arb dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_s_psel    (s_psel),
        .i_s_penable (s_penable),
        .i_s_paddr   (s_paddr),
        .i_s_pwrite  (s_pwrite),
        .i_s_pwdata  (s_pwdata),
        .i_s_pstrb   (s_pstrb),
        .i_s_pprot   (s_pprot),
        .o_s_prdata  (s_prdata),
        .o_s_pready  (s_pready),
        .o_s_pslverr (s_pslverr),
        .o_m_psel    (m_psel),
        .o_m_penable (m_penable),
        .o_m_pwrite  (m_pwrite),
        .o_m_paddr   (m_paddr),
        .o_m_pwdata  (m_pwdata),
        .o_m_pstrb   (m_pstrb),
        .o_m_pprot   (m_pprot),
        .i_m_prdata  (m_prdata),
        .i_m_pready  (m_pready),
        .i_m_pslverr (m_pslverr)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t                 exp_q0[$];
    resp_t                 exp_q1[$];
    dcd_targ_cfg_apb_req_t codec_q[$];

    int          n_pass = 0;
    int          n_total = 0;
    int          codec_setups = 0;
    int          cfg_waits = 0;
    logic        cfg_err = 1'b0;
    logic        cfg_rdata_en = 1'b0;
    logic [31:0] cfg_rdata = 32'h0;
    int          acc_cnt = 0;
    int          last_acc_cycles = 0;
    int          setups_before;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic dcd_targ_cfg_apb_req_t mk_req(input logic [19:0] a, input logic w,
            input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
        dcd_targ_cfg_apb_req_t r;
        r.addr = a; r.write = w; r.wdata = d; r.strb = s; r.prot = p;
        return r;
    endfunction

    function automatic resp_t mk_resp(input logic [31:0] d, input logic e);
        resp_t r;
        r.rdata = d; r.err = e;
        return r;
    endfunction

    // Codec target model plus codec-side monitor
    always @(negedge clk) begin
        if (m_psel && !m_penable) codec_setups++;
        if (m_psel && m_penable) begin
            m_pready  = (acc_cnt == cfg_waits);
            m_pslverr = cfg_err;
            m_prdata  = cfg_rdata_en ? cfg_rdata : (32'hA500_0000 | {12'h0, m_paddr});
            acc_cnt++;
            if (m_pready) begin
                last_acc_cycles = acc_cnt;
                if (codec_q.size() == 0) begin
                    chk("codec_unexpected", 64'(m_paddr), 64'hFFFF_FFFF);
                end else begin
                    dcd_targ_cfg_apb_req_t e;
                    e = codec_q.pop_front();
                    chk("codec_xfer", 64'({m_paddr, m_pwrite, m_pwdata, m_pstrb, m_pprot}), 64'(e));
                end
            end
        end else begin
            m_pready  = 1'b0;
            m_pslverr = 1'b0;
            m_prdata  = 32'h0;
            acc_cnt   = 0;
        end
    end

    // Requester-side response monitor
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (s_pready[i]) begin
                if ((i == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                    chk("resp_unexpected", 64'(i), 64'hFFFF);
                end else begin
                    resp_t e;
                    e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    chk(i == 0 ? "resp_req0" : "resp_req1", 64'({s_prdata[i], s_pslverr[i]}), 64'(e));
                end
            end
        end
    end

    task automatic do_req(input int idx, input dcd_targ_cfg_apb_req_t r, input resp_t exp);
        bit seen = 1'b0;
        if (idx == 0) exp_q0.push_back(exp); else exp_q1.push_back(exp);
        @(posedge clk); #1;
        s_paddr[idx]  = r.addr;
        s_pwrite[idx] = r.write;
        s_pwdata[idx] = r.wdata;
        s_pstrb[idx]  = r.strb;
        s_pprot[idx]  = r.prot;
        s_psel[idx]   = 1'b1;
        @(posedge clk); #1;
        s_penable[idx] = 1'b1;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (s_pready[idx]) seen = 1'b1;
        end
        if (!seen) chk("req_timeout", 64'(idx), 64'hFFFF);
        s_psel[idx]    = 1'b0;
        s_penable[idx] = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        s_psel = '0; s_penable = '0; s_pwrite = '0;
        s_paddr = '0; s_pwdata = '0; s_pstrb = '0; s_pprot = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        apply_reset();
        chk("reset_m", 64'({m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb, m_pprot}), 64'h0);
        chk("reset_s", 64'({s_pready, s_pslverr}), 64'h0);
        chk("reset_rdata", s_prdata, 64'h0);

        // Zero-wait read from req0, cycle-exact latency
        cfg_rdata_en = 1'b1;
        cfg_rdata    = 32'hDEAD_BEEF;
        codec_q.push_back(mk_req(20'h00100, 1'b0, 32'h0, 4'h0, 3'h0));
        exp_q0.push_back(mk_resp(32'hDEAD_BEEF, 1'b0));
        @(posedge clk); #1;
        s_paddr[0] = 20'h00100; s_pwrite[0] = 1'b0; s_pwdata[0] = '0; s_pstrb[0] = '0; s_pprot[0] = '0;
        s_psel[0] = 1'b1;
        @(negedge clk); chk("lat_c0", 64'({m_psel, m_penable}), 64'h0);
        @(negedge clk); chk("lat_c1", 64'({m_psel, m_penable}), 64'h2);
        s_penable[0] = 1'b1;
        @(negedge clk); chk("lat_c2", 64'({m_psel, m_penable}), 64'h3);
        @(negedge clk); chk("lat_c3", 64'(s_pready), 64'h1);
        s_psel[0] = 1'b0; s_penable[0] = 1'b0;
        cfg_rdata_en = 1'b0;
        repeat (2) @(posedge clk);

        // Both requesters busy from reset: grants 0,1,0,1
        apply_reset();
        setups_before = codec_setups;
        codec_q.push_back(mk_req(20'h00200, 1'b0, 32'h0, 4'h0, 3'h0));
        codec_q.push_back(mk_req(20'h00204, 1'b0, 32'h0, 4'h0, 3'h0));
        codec_q.push_back(mk_req(20'h00208, 1'b0, 32'h0, 4'h0, 3'h0));
        codec_q.push_back(mk_req(20'h0020C, 1'b0, 32'h0, 4'h0, 3'h0));
        fork
            begin
                do_req(0, mk_req(20'h00200, 1'b0, 32'h0, 4'h0, 3'h0), mk_resp(32'hA500_0200, 1'b0));
                do_req(0, mk_req(20'h00208, 1'b0, 32'h0, 4'h0, 3'h0), mk_resp(32'hA500_0208, 1'b0));
            end
            begin
                do_req(1, mk_req(20'h00204, 1'b0, 32'h0, 4'h0, 3'h0), mk_resp(32'hA500_0204, 1'b0));
                do_req(1, mk_req(20'h0020C, 1'b0, 32'h0, 4'h0, 3'h0), mk_resp(32'hA500_020C, 1'b0));
            end
        join
        chk("rr_xfer_count", 64'(codec_setups - setups_before), 64'd4);

        // Five wait states followed by an error
        cfg_waits = 5; cfg_err = 1'b1;
        setups_before = codec_setups;
        codec_q.push_back(mk_req(20'h00300, 1'b0, 32'h0, 4'h0, 3'h0));
        do_req(0, mk_req(20'h00300, 1'b0, 32'h0, 4'h0, 3'h0), mk_resp(32'hA500_0300, 1'b1));
        chk("wait_access_cycles", 64'(last_acc_cycles), 64'd6);
        chk("wait_xfer_count", 64'(codec_setups - setups_before), 64'd1);
        cfg_waits = 0; cfg_err = 1'b0;

        // Write forwarded bit-exact, read data forced to zero
        codec_q.push_back(mk_req(20'h00040, 1'b1, 32'h1234_5678, 4'h3, 3'h0));
        do_req(1, mk_req(20'h00040, 1'b1, 32'h1234_5678, 4'h3, 3'h0), mk_resp(32'h0, 1'b0));

        // Protected window, unprivileged then privileged
        setups_before = codec_setups;
`ifdef ALLEGRO_CODEC_APB_CFG_ARB_PROT_EN
        do_req(1, mk_req(20'hF0010, 1'b1, 32'hCAFE_F00D, 4'hF, 3'h0), mk_resp(32'h0, 1'b1));
        chk("prot_unpriv_xfers", 64'(codec_setups - setups_before), 64'd0);
`else
        codec_q.push_back(mk_req(20'hF0010, 1'b1, 32'hCAFE_F00D, 4'hF, 3'h0));
        do_req(1, mk_req(20'hF0010, 1'b1, 32'hCAFE_F00D, 4'hF, 3'h0), mk_resp(32'h0, 1'b0));
        chk("prot_unpriv_xfers", 64'(codec_setups - setups_before), 64'd1);
`endif
        setups_before = codec_setups;
        codec_q.push_back(mk_req(20'hF0010, 1'b1, 32'h0BAD_CAFE, 4'hF, 3'h1));
        do_req(1, mk_req(20'hF0010, 1'b1, 32'h0BAD_CAFE, 4'hF, 3'h1), mk_resp(32'h0, 1'b0));
        chk("prot_priv_xfers", 64'(codec_setups - setups_before), 64'd1);

        // Reset asserted during ACCESS
        cfg_waits = 3;
        @(posedge clk); #1;
        s_paddr[0] = 20'h00500; s_pwrite[0] = 1'b0; s_pwdata[0] = '0; s_pstrb[0] = '0; s_pprot[0] = '0;
        s_psel[0] = 1'b1;
        begin
            bit in_access = 1'b0;
            for (int c = 0; c < 20 && !in_access; c++) begin
                @(negedge clk);
                if (m_psel && m_penable) in_access = 1'b1;
            end
            chk("rst_reach_access", 64'(in_access), 64'd1);
        end
        rst_n = 1'b0;
        #1;
        chk("rst_mid_m", 64'({m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb, m_pprot}), 64'h0);
        chk("rst_mid_s", 64'({s_pready, s_pslverr}), 64'h0);
        chk("rst_mid_rdata", s_prdata, 64'h0);
        s_psel[0] = 1'b0; s_penable[0] = 1'b0;
        cfg_waits = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        codec_q.push_back(mk_req(20'h00600, 1'b0, 32'h0, 4'h0, 3'h0));
        do_req(1, mk_req(20'h00600, 1'b0, 32'h0, 4'h0, 3'h0), mk_resp(32'hA500_0600, 1'b0));

        repeat (4) @(posedge clk);
        chk("queues_drained", 64'(exp_q0.size() + exp_q1.size() + codec_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule : tb_allegro_codec_apb_cfg_arb
`default_nettype wire
